// File: rtl/cu_wb.sv
// Writeback stage: captures one instruction per 4-phase round, formats the
// load data or selects the ALU/link value, and issues a single register-file
// write strobe during stage 10.
module cu_wb #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned RF_ADDR_W = 5
) (
    input  logic                 soc_clk,
    input  logic                 WB_reset,
    input  logic                 WB_stall,
    input  logic                 WB_valid_in,
    input  logic [XLEN-1:0]      MEM_data,
    input  logic [XLEN-1:0]      ALU_result,
    input  logic [XLEN-1:0]      PC_plus4,
    input  logic [1:0]           byte_offset,
    input  logic [2:0]           funct3,
    input  logic [1:0]           wb_sel,
    input  logic [RF_ADDR_W-1:0] rd_addr,
    input  logic                 reg_write_in,
    output logic                 rf_wr_en,
    output logic [RF_ADDR_W-1:0] rf_wr_addr,
    output logic [XLEN-1:0]      rf_wr_data,
    output logic                 WB_done,
    output logic                 WB_misaligned,
    output logic                 WB_illegal,
    output logic [1:0]           WB_stage
);

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_LOAD = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;

    typedef enum logic [1:0] {
        ST_CAPTURE = 2'b00,
        ST_FORMAT  = 2'b01,
        ST_WRITE   = 2'b10,
        ST_DONE    = 2'b11
    } stage_t;

    stage_t               r_stage;
    logic                 r_pending;
    logic [XLEN-1:0]      r_mem_data;
    logic [XLEN-1:0]      r_alu;
    logic [XLEN-1:0]      r_pc4;
    logic [1:0]           r_off;
    logic [2:0]           r_f3;
    logic [1:0]           r_sel;
    logic [RF_ADDR_W-1:0] r_rd;
    logic                 r_rw;
    logic [XLEN-1:0]      r_result;
    logic                 r_mis;
    logic                 r_ill;

    logic [XLEN-1:0]      w_shifted;
    logic [XLEN-1:0]      w_load;
    logic [XLEN-1:0]      w_result;
    logic                 w_f3_bad;
    logic                 w_mis;
    logic                 w_ill;
    logic                 w_capture;
    logic                 w_write_ok;

    assign WB_stage   = r_stage;
    assign w_capture  = WB_valid_in & ~WB_stall;
    assign w_write_ok = r_pending & r_rw & (r_rd != '0) & ~r_mis & ~r_ill;

    // Load alignment/extension, result select and error detection on the captured round
    always_comb begin
        w_shifted = r_mem_data >> {r_off, 3'b000};
        w_load    = w_shifted;
        w_f3_bad  = 1'b0;
        w_mis     = 1'b0;
        w_result  = r_alu;
        case (r_f3)
            F3_LB:   w_load = {{(XLEN-8){w_shifted[7]}}, w_shifted[7:0]};
            F3_LH:   w_load = {{(XLEN-16){w_shifted[15]}}, w_shifted[15:0]};
            F3_LW:   w_load = w_shifted;
            F3_LBU:  w_load = {{(XLEN-8){1'b0}}, w_shifted[7:0]};
            F3_LHU:  w_load = {{(XLEN-16){1'b0}}, w_shifted[15:0]};
            default: w_f3_bad = 1'b1;
        endcase
        if (r_sel == SEL_LOAD) begin
            if (((r_f3 == F3_LH) || (r_f3 == F3_LHU)) && r_off[0])
                w_mis = 1'b1;
            if ((r_f3 == F3_LW) && (r_off != 2'b00))
                w_mis = 1'b1;
        end
        case (r_sel)
            SEL_ALU:  w_result = r_alu;
            SEL_LOAD: w_result = w_load;
            SEL_PC4:  w_result = r_pc4;
            default:  w_result = r_alu;
        endcase
        w_ill = (r_sel == 2'b11) || ((r_sel == SEL_LOAD) && w_f3_bad);
    end

    // Free-running stage counter and per-stage capture/format/write/done actions
    always_ff @(posedge soc_clk or posedge WB_reset) begin
        if (WB_reset) begin
            r_stage       <= ST_DONE;
            r_pending     <= 1'b0;
            r_mem_data    <= '0;
            r_alu         <= '0;
            r_pc4         <= '0;
            r_off         <= '0;
            r_f3          <= '0;
            r_sel         <= '0;
            r_rd          <= '0;
            r_rw          <= 1'b0;
            r_result      <= '0;
            r_mis         <= 1'b0;
            r_ill         <= 1'b0;
            rf_wr_en      <= 1'b0;
            rf_wr_addr    <= '0;
            rf_wr_data    <= '0;
            WB_done       <= 1'b0;
            WB_misaligned <= 1'b0;
            WB_illegal    <= 1'b0;
        end else begin
            r_stage <= stage_t'(2'(r_stage + 2'd1));
            case (r_stage)
                ST_DONE: begin
                    r_pending     <= w_capture;
                    WB_done       <= 1'b0;
                    WB_misaligned <= 1'b0;
                    WB_illegal    <= 1'b0;
                    if (w_capture) begin
                        r_mem_data <= MEM_data;
                        r_alu      <= ALU_result;
                        r_pc4      <= PC_plus4;
                        r_off      <= byte_offset;
                        r_f3       <= funct3;
                        r_sel      <= wb_sel;
                        r_rd       <= rd_addr;
                        r_rw       <= reg_write_in;
                    end
                end
                ST_CAPTURE: begin
                    r_result <= w_result;
                    r_mis    <= w_mis;
                    r_ill    <= w_ill;
                end
                ST_FORMAT: begin
                    rf_wr_en      <= w_write_ok;
                    WB_misaligned <= r_pending & r_mis;
                    WB_illegal    <= r_pending & r_ill;
                    if (w_write_ok) begin
                        rf_wr_addr <= r_rd;
                        rf_wr_data <= r_result;
                    end
                end
                ST_WRITE: begin
                    rf_wr_en <= 1'b0;
                    WB_done  <= r_pending;
                end
                default: begin
                    rf_wr_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
